channelizer_power_integrator: RTL

- Sits directly downstream of the channelizer FFT output stream (valid, channel index, signed I/Q).
- Computes per-channel instantaneous power I²+Q² and integrates it over 2^INTEGRATION_LOG2 consecutive channelizer frames.
- Emits one integrated power word per channel per integration period, for the detector/threshold logic that follows.
- Tracks channel-index ordering and resynchronises to a frame boundary on any sequence violation.

---
 rtl/channelizer_power_integrator.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/channelizer_power_integrator.sv
// Per-channel power integrator for the channelizer FFT stream: |X|^2 accumulated over
// 2^INTEGRATION_LOG2 frames, with channel-order tracking and resync on index 0.
module channelizer_power_integrator #(
    parameter int NUM_CHANNELS        = 32,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH          = 25,
    parameter int INTEGRATION_LOG2    = 4,
    parameter int OUTPUT_WIDTH        = 2*DATA_WIDTH+INTEGRATION_LOG2
) (
    input  logic                                Clk,
    input  logic                                Rst,
    input  logic                                Input_valid,
    input  logic [CHANNEL_INDEX_WIDTH-1:0]      Input_index,
    input  logic [1:0][DATA_WIDTH-1:0]          Input_data,
    output logic                                Output_valid,
    output logic [CHANNEL_INDEX_WIDTH-1:0]      Output_index,
    output logic [OUTPUT_WIDTH-1:0]             Output_power,
    output logic                                Error_sequence
);

    localparam int STAGES = 3;
    localparam int FCW    = (INTEGRATION_LOG2 > 0) ? INTEGRATION_LOG2 : 1;
    localparam int FRAMES = 1 << INTEGRATION_LOG2;
    localparam int SQW    = 2*DATA_WIDTH-1;
    localparam int PW     = 2*DATA_WIDTH;
    localparam logic [CHANNEL_INDEX_WIDTH-1:0] LAST_INDEX = CHANNEL_INDEX_WIDTH'(NUM_CHANNELS-1);
    localparam logic [FCW-1:0]                 LAST_FRAME = FCW'(FRAMES-1);

    if (NUM_CHANNELS < 8 || (NUM_CHANNELS & (NUM_CHANNELS-1)) != 0) begin : g_bad_channels
        $error("NUM_CHANNELS must be a power of two and at least 8");
    end
    if (CHANNEL_INDEX_WIDTH != $clog2(NUM_CHANNELS)) begin : g_bad_index_width
        $error("CHANNEL_INDEX_WIDTH must equal clog2(NUM_CHANNELS)");
    end
    if (OUTPUT_WIDTH != 2*DATA_WIDTH+INTEGRATION_LOG2) begin : g_bad_output_width
        $error("OUTPUT_WIDTH is derived and must not be overridden");
    end

    typedef enum logic {RESYNC, RUN} state_t;

    typedef struct packed {
        logic [CHANNEL_INDEX_WIDTH-1:0] index;
        logic                           first;
        logic                           last;
    } meta_t;

    state_t                         state;
    logic [CHANNEL_INDEX_WIDTH-1:0] expected_index;
    logic [FCW-1:0]                 frame_count;
    logic                           accept;
    logic                           seq_err;
    logic [STAGES:0]                vld_pipe;

    logic signed [DATA_WIDTH-1:0]   s1_i, s1_q;
    meta_t                          m1, m2, m3, m4;
    logic signed [PW-1:0]           prod_i, prod_q;
    logic [SQW-1:0]                 sq_i, sq_q;
    logic [PW-1:0]                  p3, p4;
    logic [OUTPUT_WIDTH-1:0]        rd4;
    logic [OUTPUT_WIDTH-1:0]        sum;
    logic [OUTPUT_WIDTH-1:0]        acc_ram [NUM_CHANNELS];
    logic                           unused_sign;

    always_comb begin
        accept  = 1'b0;
        seq_err = 1'b0;
        if (Input_valid) begin
            if (state == RESYNC)
                accept = (Input_index == '0);
            else if (Input_index == expected_index)
                accept = 1'b1;
            else
                seq_err = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state          <= RESYNC;
            expected_index <= '0;
            frame_count    <= '0;
            Error_sequence <= 1'b0;
        end else begin
            Error_sequence <= seq_err;
            if (seq_err) begin
                state          <= RESYNC;
                expected_index <= '0;
                frame_count    <= '0;
            end else if (accept) begin
                state          <= RUN;
                expected_index <= Input_index + 1'b1;
                if (Input_index == LAST_INDEX)
                    frame_count <= (frame_count == LAST_FRAME) ? '0 : frame_count + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) vld_pipe <= '0;
        else      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
    end

    // Squares of signed DATA_WIDTH values never set the product's sign bit.
    always_comb begin
        prod_i = s1_i * s1_i;
        prod_q = s1_q * s1_q;
    end
    assign unused_sign = prod_i[PW-1] ^ prod_q[PW-1];

    always_ff @(posedge Clk) begin
        s1_i     <= $signed(Input_data[0]);
        s1_q     <= $signed(Input_data[1]);
        m1.index <= Input_index;
        m1.first <= (frame_count == '0);
        m1.last  <= (frame_count == LAST_FRAME);
        sq_i     <= prod_i[SQW-1:0];
        sq_q     <= prod_q[SQW-1:0];
        m2       <= m1;
        p3       <= PW'(sq_i) + PW'(sq_q);
        m3       <= m2;
        p4       <= p3;
        rd4      <= acc_ram[m3.index];
        m4       <= m3;
    end

    // Frame 0 of each period overwrites, so the RAM never needs clearing.
    always_comb sum = m4.first ? OUTPUT_WIDTH'(p4) : rd4 + OUTPUT_WIDTH'(p4);

    always_ff @(posedge Clk) begin
        if (Rst && vld_pipe[STAGES])
            acc_ram[m4.index] <= sum;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            Output_valid <= 1'b0;
            Output_index <= '0;
            Output_power <= '0;
        end else begin
            Output_valid <= vld_pipe[STAGES] && m4.last;
            if (vld_pipe[STAGES] && m4.last) begin
                Output_index <= m4.index;
                Output_power <= sum;
            end
        end
    end

endmodule
